ysyx_22040127_wb_arbiter: RTL

Write-back arbiter and scheduler for the single GPR-file write port. It accepts register write requests from two independent producers: A = EXU/ALU result, B = LSU load data. Each producer has a small FIFO. The block grants the write port round-robin and drives the register file's `wen`/`waddr`/`wdata` from registered outputs. It also exposes a pending-write hazard query for the decode stage.

---
 rtl/ysyx_22040127_wb_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040127_wb_arbiter.sv
// Write-back arbiter: two small FIFOs (A = ALU, B = LSU) sharing one GPR write port.
// The WBARB_FWD_EN macro adds the single-match forwarding outputs q_fwd_valid/q_fwd_data.
//
// last   | meaning
// SRC_A  | A took the most recent grant; B wins the next tie
// SRC_B  | B took the most recent grant, or reset; A wins the next tie
module ysyx_22040127_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr,
`ifdef WBARB_FWD_EN
  output logic                  q_fwd_valid,
  output logic [DATA_WIDTH-1:0] q_fwd_data,
`endif
  output logic                  q_hazard
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_t;

  src_t                  last, last_next;
  logic [1:0]            in_valid, full, empty, push, grant;
  logic [ADDR_WIDTH-1:0] in_addr   [2];
  logic [DATA_WIDTH-1:0] in_data   [2];
  logic [PW:0]           wptr      [2];
  logic [PW:0]           rptr      [2];
  logic [PW:0]           occ       [2];
  logic [ADDR_WIDTH-1:0] mem_addr  [2][DEPTH];
  logic [DATA_WIDTH-1:0] mem_data  [2][DEPTH];
  logic [ADDR_WIDTH-1:0] head_addr [2];
  logic [DATA_WIDTH-1:0] head_data [2];
  logic [DEPTH-1:0]      slot_valid[2];

  assign in_valid = {b_valid, a_valid};
  assign in_addr  = '{a_addr, b_addr};
  assign in_data  = '{a_data, b_data};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      full[s]      = (wptr[s][PW-1:0] == rptr[s][PW-1:0]) && (wptr[s][PW] != rptr[s][PW]);
      empty[s]     = (wptr[s] == rptr[s]);
      occ[s]       = wptr[s] - rptr[s];
      // Address-0 requests complete the handshake but never occupy a slot.
      push[s]      = in_valid[s] && !full[s] && (in_addr[s] != '0);
      head_addr[s] = mem_addr[s][rptr[s][PW-1:0]];
      head_data[s] = mem_data[s][rptr[s][PW-1:0]];
      for (int i = 0; i < DEPTH; i++)
        slot_valid[s][i] = {1'b0, PW'(i) - rptr[s][PW-1:0]} < occ[s];
    end
  end

  assign a_ready = !full[0];
  assign b_ready = !full[1];

  always_comb begin
    grant[0]  = !empty[0] && (empty[1] || last == SRC_B);
    grant[1]  = !empty[1] && (empty[0] || last == SRC_A);
    last_next = last;
    if (grant[0])      last_next = SRC_A;
    else if (grant[1]) last_next = SRC_B;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= SRC_B;
    else     last <= last_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s])  wptr[s] <= wptr[s] + 1'b1;
        if (grant[s]) rptr[s] <= rptr[s] + 1'b1;
      end
    end
  end

  // Storage needs no reset: slot validity comes only from the pointers.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_addr[s][wptr[s][PW-1:0]] <= in_addr[s];
        mem_data[s][wptr[s][PW-1:0]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grant[0]) begin
      rf_wen   <= 1'b1;
      rf_waddr <= head_addr[0];
      rf_wdata <= head_data[0];
    end else if (grant[1]) begin
      rf_wen   <= 1'b1;
      rf_waddr <= head_addr[1];
      rf_wdata <= head_data[1];
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  logic                  hit_any, hit_multi;
  logic [DATA_WIDTH-1:0] hit_data;

  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_data  = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[s][i] && mem_addr[s][i] == q_addr) begin
          if (hit_any) hit_multi = 1'b1;
          hit_any  = 1'b1;
          hit_data = mem_data[s][i];
        end
      end
    end
    if (rf_wen && rf_waddr == q_addr) begin
      if (hit_any) hit_multi = 1'b1;
      hit_any  = 1'b1;
      hit_data = rf_wdata;
    end
    if (q_addr == '0) begin
      hit_any   = 1'b0;
      hit_multi = 1'b0;
    end
  end

  assign q_hazard = hit_any;

`ifdef WBARB_FWD_EN
  assign q_fwd_valid = hit_any && !hit_multi;
  assign q_fwd_data  = (hit_any && !hit_multi) ? hit_data : '0;
`else
  logic unused_fwd;
  assign unused_fwd = hit_multi ^ (^hit_data);
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        assert (occ[s] <= (PW+1)'(DEPTH));
        assert (!(grant[s] && empty[s]));
        assert (!(push[s] && full[s]));
      end
    end
  end
`endif

endmodule
